// File: rtl/mem_pkg.sv
// Shared types and constants for the MIPS shared instruction/data memory controller.
package mem_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DEPTH  = 64;

   // Wait-state counter width; holds LATENCY values 0..15.
   localparam int LAT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   typedef enum logic {
      GNT_I,
      GNT_D
   } gnt_t;

endpackage

// File: rtl/mem_array.sv
// Word-organised storage array: synchronous byte-enable write, combinational read.
// Storage has no reset; contents persist across controller resets.
module mem_array
   import mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [DATA_W/8-1:0]        be,
   input  logic [$clog2(DEPTH)-1:0]   idx,
   input  logic [DATA_W-1:0]          wdata,
   output logic [DATA_W-1:0]          rdata
);

   localparam int BE_W = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

   // Update only the byte lanes whose enable is set; an all-zero mask leaves the word intact.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int k = 0; k < BE_W; k++) begin
            if (be[k]) begin
               mem[idx][8*k +: 8] <= wdata[8*k +: 8];
            end
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/mips_mem_ctrl.sv
// Shared fetch/data memory controller with req/ready handshake, LATENCY wait states,
// byte-enable writes and misaligned/out-of-range error reporting.
// Optional macro MEM_RR_ARB_EN: round-robin arbitration instead of data-over-fetch priority.
module mips_mem_ctrl
   import mem_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_req,
   input  logic [ADDR_W-1:0]    i_addr,
   output logic                 i_ready,
   output logic [DATA_W-1:0]    i_rdata,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [DATA_W/8-1:0]  d_be,
   input  logic [ADDR_W-1:0]    d_addr,
   input  logic [DATA_W-1:0]    d_wdata,
   output logic                 d_ready,
   output logic [DATA_W-1:0]    d_rdata,
   output logic                 err
);

   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = $clog2(DEPTH);
   // One extra bit so the byte limit never overflows a narrow address.
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * 4);

   state_t              state_q, state_d;
   gnt_t                grant_q, grant_d;
   gnt_t                pick;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [BE_W-1:0]     be_q, be_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [LAT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   iRdata_q, dRdata_q;
   logic [DATA_W-1:0]   arrayRdata;
   logic [IDX_W-1:0]    wordIdx;
   logic                accessErr;
   logic                commit;
   logic                anyReq;

   assign anyReq    = i_req | d_req;
   assign wordIdx   = addr_q[IDX_W+1:2];
   assign accessErr = (addr_q[1:0] != 2'b00) || ({1'b0, addr_q} >= LIMIT);
   assign commit    = (state_q == BUSY) && (cnt_q == '0);

`ifdef MEM_RR_ARB_EN
   gnt_t lastGnt_q;

   // On a tie, serve whichever port was not served last; otherwise serve the lone requester.
   always_comb begin
      pick = GNT_I;
      if (i_req && d_req) begin
         pick = (lastGnt_q == GNT_I) ? GNT_D : GNT_I;
      end else if (d_req) begin
         pick = GNT_D;
      end
   end

   // Remember the last granted port; starting at fetch-last lets data win the first tie.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lastGnt_q <= GNT_I;
      end else if ((state_q == IDLE) && anyReq) begin
         lastGnt_q <= pick;
      end
   end
`else
   // Data requests always beat fetch requests.
   always_comb begin
      pick = d_req ? GNT_D : GNT_I;
   end
`endif

   // Next-state logic: capture the granted request in IDLE, count wait states in BUSY,
   // spend exactly one cycle in RESP for the ready pulse.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      addr_d  = addr_q;
      we_d    = we_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (anyReq) begin
               grant_d = pick;
               cnt_d   = LAT_W'(LATENCY);
               state_d = BUSY;
               if (pick == GNT_D) begin
                  addr_d  = d_addr;
                  we_d    = d_we;
                  be_d    = d_be;
                  wdata_d = d_wdata;
               end else begin
                  addr_d  = i_addr;
                  we_d    = 1'b0;
                  be_d    = '0;
                  wdata_d = '0;
               end
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - LAT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and captured-request registers; reset aborts any access in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         grant_q <= GNT_I;
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
      end
   end

   // Load the granted port's read register at the commit edge; errors return zero,
   // good writes leave it alone, and the other port's register is never touched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         iRdata_q <= '0;
         dRdata_q <= '0;
      end else if (commit) begin
         if (accessErr) begin
            if (grant_q == GNT_D) begin
               dRdata_q <= '0;
            end else begin
               iRdata_q <= '0;
            end
         end else if (!we_q) begin
            if (grant_q == GNT_D) begin
               dRdata_q <= arrayRdata;
            end else begin
               iRdata_q <= arrayRdata;
            end
         end
      end
   end

   mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (commit && we_q && !accessErr),
      .be    (be_q),
      .idx   (wordIdx),
      .wdata (wdata_q),
      .rdata (arrayRdata)
   );

   assign i_ready = (state_q == RESP) && (grant_q == GNT_I);
   assign d_ready = (state_q == RESP) && (grant_q == GNT_D);
   assign err     = (state_q == RESP) && accessErr;
   assign i_rdata = iRdata_q;
   assign d_rdata = dRdata_q;

endmodule
